// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
//   Pipeline controller for the in-order core. Owns the fetch PC, the
//   per-stage valid bits, stall and bubble generation, branch-redirect flush
//   and load-use hazard detection. Drives the load-enable and bubble controls
//   of every inter-stage register.
//
//   Stage 0 = IF, 1 = ID, ..., STAGES-1 = WB.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   stall_req_i         per-stage hold request
//   redirect_valid_i    redirect request from stage REDIR_STAGE
//   redirect_pc_i       redirect target
//   id_re*/id_raddr*    ID-stage register read enables / addresses
//   ex_we_i, ex_is_load_i, ex_waddr_i   EX-stage write info
//   pc_o, ce_o          registered fetch address / fetch enable
//   stage_valid_o       registered valid bit per stage
//   stage_en_o          bit 0: PC update, bit k: register feeding stage k loads
//   stage_bubble_o      bit k: register feeding stage k loads a bubble
//   hazard_o            load-use hazard (combinational)
//   stall_cnt_o         saturating count of stalled cycles
// ----------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int                STAGES      = 5,
   parameter int                ADDR_W      = 32,
   parameter int                REG_AW      = 5,
   parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(32'h1c000000),
   parameter int                PC_STEP     = 4,
   parameter int                REDIR_STAGE = 2,
   parameter int                CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [STAGES-1:0] stall_req_i,
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   input  logic              id_re1_i,
   input  logic              id_re2_i,
   input  logic [REG_AW-1:0] id_raddr1_i,
   input  logic [REG_AW-1:0] id_raddr2_i,
   input  logic              ex_we_i,
   input  logic              ex_is_load_i,
   input  logic [REG_AW-1:0] ex_waddr_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              ce_o,
   output logic [STAGES-1:0] stage_valid_o,
   output logic [STAGES-1:0] stage_en_o,
   output logic [STAGES-1:0] stage_bubble_o,
   output logic              hazard_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              ce_q, ce_d;
   logic [STAGES-1:1] valid_q, valid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [STAGES-1:0] valid_all;
   logic [STAGES-1:0] stall_eff;
   logic [STAGES-1:0] en;
   logic [STAGES-1:0] bubble;
   logic              hazard;
   logic              blocking;
   logic              redir_acc;
   logic              any_stall;

   // Stage 0 is valid exactly when fetch is enabled.
   assign valid_all = {valid_q, ce_q};

   assign hazard = ex_is_load_i & ex_we_i & (ex_waddr_i != '0) &
                   valid_all[1] & valid_all[2] &
                   ((id_re1_i & (id_raddr1_i == ex_waddr_i)) |
                    (id_re2_i & (id_raddr2_i == ex_waddr_i)));

   always_comb begin
      int s;
      stall_eff    = stall_req_i;
      stall_eff[1] = stall_req_i[1] | hazard;
      any_stall    = |stall_eff;

      // A stall at or beyond the redirecting stage holds that stage, so its
      // redirect cannot be taken this cycle.
      blocking = 1'b0;
      s        = -1;
      for (int k = 0; k < STAGES; k++) begin
         if (stall_eff[k]) begin
            s = k;
            if (k >= REDIR_STAGE) blocking = 1'b1;
         end
      end
      redir_acc = redirect_valid_i & ~blocking;

      en     = '1;
      bubble = '0;
      if (redir_acc) begin
         for (int k = 1; k < STAGES; k++)
            bubble[k] = (k <= REDIR_STAGE);
      end else if (any_stall) begin
         // Everything up to the highest stalled stage holds; the stage just
         // behind it takes a bubble so nothing is duplicated downstream.
         for (int k = 0; k < STAGES; k++) begin
            en[k]     = (k > s);
            bubble[k] = (k == s + 1);
         end
      end
   end

   always_comb begin
      ce_d    = 1'b1;
      pc_d    = pc_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (ce_q && en[0])
         pc_d = redir_acc ? redirect_pc_i : pc_q + ADDR_W'(PC_STEP);
      for (int k = 1; k < STAGES; k++) begin
         if (en[k]) valid_d[k] = bubble[k] ? 1'b0 : valid_all[k-1];
      end
      if (ce_q && any_stall) cnt_d = sat_inc(cnt_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         ce_q    <= 1'b0;
         valid_q <= '0;
         cnt_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         ce_q    <= ce_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc_o           = pc_q;
   assign ce_o           = ce_q;
   assign stage_valid_o  = valid_all;
   assign stage_en_o     = en;
   assign stage_bubble_o = bubble;
   assign hazard_o       = hazard;
   assign stall_cnt_o    = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic [4:0]  stall_req;
   logic        redir_v;
   logic [31:0] redir_pc;
   logic        re1, re2;
   logic [4:0]  raddr1, raddr2;
   logic        ex_we, ex_ld;
   logic [4:0]  ex_waddr;

   logic [31:0] pc;
   logic        ce;
   logic [4:0]  valid, en, bub;
   logic        hz;
   logic [3:0]  cnt;

   logic [7:0]  w_pc;
   logic        w_ce;
   logic [4:0]  w_valid, w_en, w_bub;
   logic        w_hz;
   logic [31:0] w_cnt;

   int checks = 0;
   int fails  = 0;

   pipe_ctrl #(.STAGES(5), .ADDR_W(32), .CNT_W(4)) u_dut (
      .clk(clk), .rst(rst), .stall_req_i(stall_req),
      .redirect_valid_i(redir_v), .redirect_pc_i(redir_pc),
      .id_re1_i(re1), .id_re2_i(re2), .id_raddr1_i(raddr1), .id_raddr2_i(raddr2),
      .ex_we_i(ex_we), .ex_is_load_i(ex_ld), .ex_waddr_i(ex_waddr),
      .pc_o(pc), .ce_o(ce), .stage_valid_o(valid), .stage_en_o(en),
      .stage_bubble_o(bub), .hazard_o(hz), .stall_cnt_o(cnt)
   );

   pipe_ctrl #(.STAGES(5), .ADDR_W(8), .RESET_PC(8'hFC)) u_wrap (
      .clk(clk), .rst(rst), .stall_req_i(5'b0),
      .redirect_valid_i(1'b0), .redirect_pc_i(8'h00),
      .id_re1_i(1'b0), .id_re2_i(1'b0), .id_raddr1_i(5'd0), .id_raddr2_i(5'd0),
      .ex_we_i(1'b0), .ex_is_load_i(1'b0), .ex_waddr_i(5'd0),
      .pc_o(w_pc), .ce_o(w_ce), .stage_valid_o(w_valid), .stage_en_o(w_en),
      .stage_bubble_o(w_bub), .hazard_o(w_hz), .stall_cnt_o(w_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall_req = '0; redir_v = 1'b0; redir_pc = '0;
      re1 = 1'b0; re2 = 1'b0; raddr1 = '0; raddr2 = '0;
      ex_we = 1'b0; ex_ld = 1'b0; ex_waddr = '0;
      #2;
      chk("rst_pc", pc, 32'h1c000000);
      chk("rst_ce", ce, 0);
      chk("rst_valid", valid, 5'b00000);
      chk("rst_cnt", cnt, 0);
      chk("rst_wpc", w_pc, 8'hFC);
      step(); step();
      rst = 1'b0;

      // Fill
      step();
      chk("fill1_ce", ce, 1);
      chk("fill1_pc", pc, 32'h1c000000);
      chk("fill1_valid", valid, 5'b00001);
      chk("fill1_wpc", w_pc, 8'hFC);
      step();
      chk("fill2_pc", pc, 32'h1c000004);
      chk("fill2_valid", valid, 5'b00011);
      chk("wrap_pc", w_pc, 8'h00);
      step();
      chk("fill3_pc", pc, 32'h1c000008);
      chk("fill3_valid", valid, 5'b00111);
      chk("wrap_pc2", w_pc, 8'h04);
      step();
      chk("fill4_valid", valid, 5'b01111);
      step();
      chk("fill5_pc", pc, 32'h1c000010);
      chk("fill5_valid", valid, 5'b11111);
      chk("free_en", en, 5'b11111);
      chk("free_hz", hz, 0);

      // Load-use hazard
      ex_ld = 1'b1; ex_we = 1'b1; ex_waddr = 5'd5; re1 = 1'b1; raddr1 = 5'd5;
      #1;
      chk("lu_hz", hz, 1);
      chk("lu_en", en, 5'b11100);
      chk("lu_bub", bub, 5'b00100);
      ex_waddr = 5'd0; raddr1 = 5'd0;
      #1;
      chk("lu_r0_hz", hz, 0);
      chk("lu_r0_en", en, 5'b11111);
      re1 = 1'b0; re2 = 1'b1; raddr2 = 5'd7; ex_waddr = 5'd7;
      #1;
      chk("lu_re2_hz", hz, 1);
      re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b0; ex_waddr = 5'd5;
      step();
      chk("lu_pc_hold", pc, 32'h1c000010);
      chk("lu_valid", valid, 5'b11011);
      chk("lu_cnt", cnt, 1);
      ex_ld = 1'b0; ex_we = 1'b0; re1 = 1'b0; ex_waddr = '0; raddr1 = '0; raddr2 = '0;
      step(); step(); step();
      chk("refill_pc", pc, 32'h1c00001c);
      chk("refill_valid", valid, 5'b11111);

      // Redirect alone
      redir_v = 1'b1; redir_pc = 32'h1c000100;
      #1;
      chk("rd_en", en, 5'b11111);
      chk("rd_bub", bub, 5'b00110);
      step();
      chk("rd_pc", pc, 32'h1c000100);
      chk("rd_valid", valid, 5'b11001);
      chk("rd_cnt", cnt, 1);

      // Redirect beats a lower-stage stall
      redir_pc = 32'h1c000200; stall_req = 5'b00010;
      #1;
      chk("rds_en", en, 5'b11111);
      chk("rds_bub", bub, 5'b00110);
      step();
      chk("rds_pc", pc, 32'h1c000200);
      chk("rds_valid", valid, 5'b10001);

      // Redirect blocked by a stall at stage 3
      redir_pc = 32'h1c000300; stall_req = 5'b01000;
      #1;
      chk("blk_en", en, 5'b10000);
      chk("blk_bub", bub, 5'b10000);
      step();
      chk("blk_pc", pc, 32'h1c000200);
      chk("blk_valid", valid, 5'b00001);

      // Full freeze and counter saturation
      redir_v = 1'b0; stall_req = 5'b10000;
      #1;
      chk("frz_en", en, 5'b00000);
      chk("frz_bub", bub, 5'b00000);
      for (int i = 0; i < 20; i++) step();
      chk("frz_cnt", cnt, 4'd15);
      chk("frz_valid", valid, 5'b00001);
      chk("frz_pc", pc, 32'h1c000200);
      stall_req = '0;
      step();
      chk("run_pc", pc, 32'h1c000204);
      chk("run_cnt", cnt, 4'd15);

      // Asynchronous reset in mid-cycle
      #2;
      rst = 1'b1;
      #1;
      chk("arst_pc", pc, 32'h1c000000);
      chk("arst_ce", ce, 0);
      chk("arst_valid", valid, 5'b00000);
      chk("arst_cnt", cnt, 0);
      chk("arst_wpc", w_pc, 8'hFC);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline controller for the in-order LoongArch core: owns the PC, per-stage valid bits, stall/bubble generation, branch redirect flush and load-use hazard detection.
- Drives the update-enable and bubble controls of every inter-stage register (If2Id, Id2Ex, Ex2Mem, Mem2Wb, ...).
- The fixed 5-stage datapath without stall/flush becomes an N-stage pipeline with hazard handling.
- Stage index 0 = IF, 1 = ID, ..., STAGES-1 = WB.

Parameters:
- STAGES, 5, pipeline depth, legal range 3..8.
- ADDR_W, 32, PC width.
- REG_AW, 5, register address width.
- RESET_PC, 32'h1c000000, PC after reset, truncated to ADDR_W.
- PC_STEP, 4, sequential PC increment.
- REDIR_STAGE, 2, stage issuing redirects, legal range 1..STAGES-2.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_req_i  in  STAGES  bit k: stage k requests hold this cycle.
- redirect_valid_i  in  1  redirect request from stage REDIR_STAGE.
- redirect_pc_i  in  ADDR_W  redirect target.
- id_re1_i, id_re2_i  in  1 each  ID read enables.
- id_raddr1_i, id_raddr2_i  in  REG_AW each  ID read addresses.
- ex_we_i  in  1  EX-stage instruction writes a register.
- ex_is_load_i  in  1  EX-stage instruction is a load.
- ex_waddr_i  in  REG_AW  EX-stage destination register.
- pc_o  out  ADDR_W  fetch address, registered.
- ce_o  out  1  fetch enable, registered.
- stage_valid_o  out  STAGES  registered valid bit per stage.
- stage_en_o  out  STAGES  bit 0: PC update; bit k≥1: register feeding stage k loads.
- stage_bubble_o  out  STAGES  bit k≥1: register feeding stage k loads a bubble. Bit 0 is always 0.
- hazard_o  out  1  load-use hazard detected, combinational.
- stall_cnt_o  out  CNT_W  count of stalled cycles, saturating.

Behaviour:
- Reset values (immediate on rst assertion, independent of clk): pc_o=RESET_PC, ce_o=0, stage_valid_o=0, stall_cnt_o=0.
- ce_o becomes 1 on the first edge after rst deasserts and then stays 1.
- stage_valid_o[0] equals ce_o.
- Load-use hazard: hazard_o = ex_is_load_i & ex_we_i & (ex_waddr_i≠0) & stage_valid_o[1] & stage_valid_o[2] & ((id_re1_i & id_raddr1_i==ex_waddr_i) | (id_re2_i & id_raddr2_i==ex_waddr_i)).
- Effective stall vector: stall_eff = stall_req_i, with bit 1 additionally OR'd with hazard_o.
- Control outputs (stage_en_o, stage_bubble_o, hazard_o) are combinational in the current cycle.
- Priority, highest first:
  1. Blocking stall: stall_eff[k]=1 for some k≥REDIR_STAGE. Any redirect is ignored this cycle; the redirecting stage is held and must re-assert.
  2. Redirect: redirect_valid_i=1 and no blocking stall.
  3. Ordinary stall: any remaining stall_eff bit.
  4. Free run.
- Stall rule (s = highest k with stall_eff[k]=1):
  - en[k]=0 for k≤s.
  - If s+1<STAGES: en[s+1]=1 and bubble[s+1]=1.
  - en=1, bubble=0 for k>s+1.
  - s=STAGES-1 freezes the whole pipeline with no bubble.
- Redirect rule:
  - en=all ones; bubble[k]=1 for 1≤k≤REDIR_STAGE, 0 otherwise.
  - PC loads redirect_pc_i.
  - Lower-stage stalls are overridden.
- Free run: en=all ones, bubble=0.
- Valid update for k≥1 on each edge: if en[k], valid[k] ← bubble[k] ? 0 : valid[k-1]; otherwise hold.
- PC update: if ce_o & en[0], pc ← redirect accepted ? redirect_pc_i : pc+PC_STEP, modulo 2^ADDR_W (wraps silently). Otherwise hold.
- Before ce_o=1, pc stays RESET_PC.
- Stall counter: increments when ce_o & (|stall_eff) and stall_cnt_o is not all-ones; saturates at 2^CNT_W-1.
- Redirects are not counted as stalls.

Test Plan:
- Reset/fill (defaults): release rst → ce_o=1 after 1 edge; pc_o sequence 1c000000, 1c000004, 1c000008...; stage_valid_o 00001, 00011, 00111, 01111, 11111.
- Load-use: full pipe, ex_is_load_i=1, ex_we_i=1, ex_waddr_i=5, id_re1_i=1, id_raddr1_i=5 → hazard_o=1, stage_en_o=11100, stage_bubble_o=00100; pc held; next cycle valid[2]=0. Repeat with ex_waddr_i=0 → hazard_o=0.
- Redirect: full pipe, redirect_valid_i=1, redirect_pc_i=1c000100 → next pc_o=1c000100, valid[1]=valid[2]=0, valid[3] takes the old valid[2]; with stall_req_i[1]=1 asserted simultaneously, the redirect still wins.
- Blocked redirect: redirect_valid_i=1 with stall_req_i[3]=1 → pc unchanged, stage_en_o=10000, stage_bubble_o=10000.
- Freeze + saturation (CNT_W=4): stall_req_i[4]=1 for 20 cycles → stage_en_o=00000, valid held, stall_cnt_o ends at 15.
- Wrap and async reset (ADDR_W=8, RESET_PC=8'hFC): one advance → pc_o=00. Assert rst mid-cycle → outputs reset before the next edge.
